// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter.
// One bit per clock; result held in res until the next conversion ends.
module bin2bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic [7:0]     out,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]   sh, sh_nx;
  logic [4*D-1:0] acc, acc_adj, acc_sh;
  logic [4*D-1:0] res;
  logic [CW-1:0]  cnt;
  logic           done_r;
  logic           last;

  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SHIFT;
      SHIFT: if (last)  state_nx = IDLE;
    endcase
  end

  // Digit corrections are independent; no carry crosses a digit.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign {acc_sh, sh_nx} = {acc_adj, sh} << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      res    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sh  <= sh_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            res    <= acc_sh;
            done_r <= 1'b1;
          end else begin
            acc <= acc_sh;
          end
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = done_r;
  assign bcd  = res;
  assign out  = res[7:0];

  generate
    if (D > 2) begin : g_ovf
      assign ovf = |res[4*D-1:8];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq.
// Expected digits come from plain decimal arithmetic on the input value.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [7:0]  out;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bin2bcd_seq #(.W(8), .D(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .out   (out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion while idle; return cycles to done and busy count.
  task automatic run(input logic [7:0] v, output int lat, output int bcyc);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 8'($urandom);
    lat   = 0;
    bcyc  = 0;
    while (!done && lat < 20) begin
      if (busy) bcyc++;
      tick();
      lat++;
    end
  endtask

  task automatic conv_chk(input string tag, input logic [7:0] v);
    int lat, bcyc;
    run(v, lat, bcyc);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(int'(v))));
  endtask

  initial begin
    int lat, bcyc, nd, nb, prev, bad_out;
    logic [7:0] v;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    tick();

    run(8'd255, lat, bcyc);
    chk("t255_lat", 32'(lat), 8);
    chk("t255_busy", 32'(bcyc), 8);
    chk("t255_bcd", 32'(bcd), 32'h255);
    chk("t255_out", 32'(out), 32'h55);
    chk("t255_ovf", 32'(ovf), 1);
    tick();
    chk("t255_pulse", 32'(done), 0);
    chk("t255_hold", 32'(bcd), 32'h255);

    conv_chk("b0", 8'd0);
    chk("b0_ovf", 32'(ovf), 0);
    conv_chk("b99", 8'd99);
    chk("b99_ovf", 32'(ovf), 0);
    chk("b99_out", 32'(out), 32'h99);
    conv_chk("b100", 8'd100);
    chk("b100_ovf", 32'(ovf), 1);

    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      run(v, lat, bcyc);
      chk("sw_lat", 32'(lat), 8);
      chk("sw_bcd", 32'(bcd), 32'(ref_bcd(i)));
      chk("sw_ovf", 32'(ovf), 32'(i >= 100));
    end

    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
      run(v, lat, bcyc);
      chk("rnd_lat", 32'(lat), 8);
      chk("rnd_bcd", 32'(bcd), 32'(ref_bcd(int'(v))));
    end

    // start re-pulsed mid-conversion must be ignored
    tick();
    bin   = 8'd37;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        bin   = 8'd200;
        start = 1'b1;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (busy) nb++;
      if (done) nd++;
      tick();
    end
    chk("ign_done", 32'(nd), 1);
    chk("ign_busy", 32'(nb), 8);
    chk("ign_bcd", 32'(bcd), 32'h037);

    // reset in the middle of a conversion
    conv_chk("pre42", 8'd42);
    bin   = 8'd123;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_bcd", 32'(bcd), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_out", 32'(out), 0);
    chk("mrst_ovf", 32'(ovf), 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nd++;
      tick();
    end
    chk("mrst_quiet", 32'(nd), 0);
    conv_chk("post123", 8'd123);

    // start held high: one conversion per 9 cycles
    conv_chk("pre12", 8'd12);
    bin   = 8'd77;
    start = 1'b1;
    nd = 0;
    prev = -1;
    bad_out = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        nd++;
        chk("hold_bcd", 32'(bcd), 32'h077);
        if (prev >= 0) chk("hold_gap", 32'(i - prev), 9);
        else chk("hold_first", 32'(i), 9);
        prev = i;
      end
      if (prev >= 0 && out !== 8'h77) bad_out++;
      if (prev < 0 && out !== 8'h12) bad_out++;
    end
    chk("hold_ndone", 32'(nd), 4);
    chk("hold_out", 32'(bad_out), 0);
    start = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the two-digit seven-segment display FSM. It converts an unsigned binary value to packed BCD on a start/done handshake and holds the result, so the display shows decimal digits instead of raw hex nibbles. Its 8-bit `out` port drives the display FSM's 8-bit `out` input without any glue logic: tens digit in `[7:4]`, ones digit in `[3:0]`.

## Interface
- `W`, 8: width of the binary input; also the number of conversion cycles.
- `D`, 3: number of BCD digits produced; must satisfy 10^D > 2^W - 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  conversion request; sampled only while idle.
- `bin`  in  W  unsigned binary value; captured on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse: a new result is valid.
- `bcd`  out  4*D  packed BCD result, least significant digit in `[3:0]`; holds until the next conversion completes.
- `out`  out  8  `bcd[7:0]`, feeding the display FSM.
- `ovf`  out  1  high when any digit above the tens digit is nonzero, i.e. the value does not fit on two digits.

## Operation
- States: IDLE and SHIFT.
- Registers:
  - `sh`: W-bit binary shift register.
  - `acc`: 4*D-bit BCD scratch accumulator.
  - `cnt`: iteration counter, ceil(log2(W+1)) bits.
  - `res`: 4*D-bit result register.
  - `done_r`: done pulse register.
- IDLE with `start`=1:
  - `sh` <= `bin`, `acc` <= 0, `cnt` <= 0.
  - Next state is SHIFT.
- IDLE with `start`=0: all registers hold.
- SHIFT, every cycle:
  - Each 4-bit digit of `acc` that is 5 or greater gets 3 added. The adds are computed in parallel from the current `acc`.
  - The adjusted `acc` and `sh` are then shifted left together as one {acc,sh} vector, one bit. The MSB of `sh` enters the LSB of `acc`.
  - `cnt` increments.
- SHIFT when `cnt` = W-1 (final iteration):
  - The shifted value is written into `res` rather than `acc`.
  - `done_r` <= 1.
  - Next state is IDLE.
- `done_r` is cleared on every other edge, so `done` is exactly one cycle wide.
- Output assignments:
  - `busy` = (state == SHIFT).
  - `bcd` = `res`.
  - `out` = `res[7:0]`.
  - `ovf` = OR of `res[4*D-1:8]`.
  - All outputs come from registers or state; no output depends combinationally on `start` or `bin`.
- Arithmetic: digit add-3 is a 4-bit add with no carry between digits. The precondition guarantees digits never exceed 9 after a shift.
- `start` while busy is ignored: no queuing, no restart, and the result is not disturbed.
- `bin` changing after the accepting edge has no effect.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE
  - `sh`, `acc`, `cnt`, `res` = 0
  - `done`=0, `busy`=0, `bcd`=0, `out`=0x00, `ovf`=0
- Reset has priority over everything, including in the middle of a conversion. A conversion interrupted by reset produces no `done` and leaves `res` = 0.
- Conversion timing, with `start` accepted at edge E0:
  - `busy` is high for the W cycles following E0.
  - At edge E_W (W edges after E0), `res` updates, `busy` falls, and `done` rises for one cycle.
- Latency: W cycles from the accepting edge to the result; 8 for the defaults.
- Back-to-back conversions:
  - A new `start` is accepted on the edge that ends the `done` cycle, since the block is already IDLE.
  - Throughput is therefore one conversion per W+1 cycles.
- During the accepted-while-done case, `res` holds the previous result until the new conversion's E_W edge.
- `out` is stable between `done` pulses, so the downstream display never shows a partially converted value.

## Test plan
- Reset, then `bin`=255 with `start` pulsed one cycle -> `busy` high for exactly 8 cycles; `done` pulses once on the 8th edge; `bcd`=0x255, `out`=0x55, `ovf`=1.
- `bin`=0, then `bin`=99, then `bin`=100 -> `bcd` = 0x000, 0x099, 0x100 respectively; `ovf` = 0, 0, 1.
- Exhaustive sweep of `bin` 0..255 -> for every value, `bcd` equals the decimal digits of `bin`; `done` occurs exactly 8 cycles after each accepting edge.
- `bin`=37 started, then `start` re-pulsed with `bin`=200 during busy cycle 4 -> only one `done`; result 0x037; no second conversion runs.
- Previous result 0x042, then `rst_n`=0 for one cycle at busy cycle 5 of converting 123 -> all outputs 0 the next cycle; no `done` follows; a subsequent convert of 123 yields 0x123.
- Result 0x012 completes, then `start` held high continuously with `bin`=77 -> conversions accepted every 9 cycles; each `done` carries 0x077; `out` holds 0x77 between pulses.
